// File: rtl/glyph_rom_arbiter.sv
// Two-requester glyph ROM arbiter with burst locking and a lock timeout.
// Optional GLYPH_ARB_STATS_EN adds a saturating conflict-cycle counter.
module glyph_rom_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 7,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        owner
`ifdef GLYPH_ARB_STATS_EN
    ,
    output logic [15:0]       conflicts
`endif
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             last_gnt;
    logic             last_gnt_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // last_gnt names the requester granted most recently; the other wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OWN0: gnt0 = req0;
            OWN1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = last_gnt;
                    gnt1 = !last_gnt;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        last_gnt_nx = last_gnt;
        if (gnt0) begin
            last_gnt_nx = 1'b0;
        end else if (gnt1) begin
            last_gnt_nx = 1'b1;
        end
        case (state)
            OWN0: begin
                if (!lock0) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx    = IDLE;
                    last_gnt_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            OWN1: begin
                if (!lock1) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx    = IDLE;
                    last_gnt_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                if (gnt0 && lock0) begin
                    state_nx = OWN0;
                end else if (gnt1 && lock1) begin
                    state_nx = OWN1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_nx;
            last_gnt <= last_gnt_nx;
            cnt      <= cnt_nx;
            rvalid0  <= gnt0;
            rvalid1  <= gnt1;
        end
    end

    assign owner  = state;
    assign rom_rd = gnt0 | gnt1;
    assign rdata  = rom_data;

    always_comb begin
        rom_addr = '0;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

`ifdef GLYPH_ARB_STATS_EN
    logic conflict_hit;

    assign conflict_hit = (req0 && !gnt0) || (req1 && !gnt1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            conflicts <= '0;
        end else if (conflict_hit && conflicts != 16'hFFFF) begin
            conflicts <= conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Bench for glyph_rom_arbiter: vector table plus burst, timeout and reset sequences.
// Instance a uses default LOCK_MAX, instance b uses LOCK_MAX=8.
module tb_glyph_rom_arbiter;

    localparam int AW = 7;
    localparam int DW = 7;

    typedef struct {
        logic          r0;
        logic          r1;
        logic          l0;
        logic          l1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          e0;
        logic          e1;
        logic [1:0]    own;
    } vec_t;

    typedef struct {
        logic          v0;
        logic          v1;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic          sel = 1'b0;

    logic          gnt0_a, gnt1_a, rv0_a, rv1_a, rd_a;
    logic          gnt0_b, gnt1_b, rv0_b, rv1_b, rd_b;
    logic [DW-1:0] rdata_a, rdata_b, romd_a, romd_b;
    logic [AW-1:0] radr_a, radr_b;
    logic [1:0]    own_a, own_b;
`ifdef GLYPH_ARB_STATS_EN
    logic [15:0]   conf_a, conf_b;
`endif

    logic          gnt0, gnt1, rvalid0, rvalid1, rom_rd;
    logic [DW-1:0] rdata;
    logic [AW-1:0] rom_addr;
    logic [1:0]    owner;

    int total = 0;
    int bad = 0;
    int stepno = 0;
    exp_t sbq[$];
    vec_t tbl[14];

    glyph_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk_in(clk_in), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0_a), .gnt1(gnt1_a),
        .rvalid0(rv0_a), .rvalid1(rv1_a),
        .rdata(rdata_a),
        .rom_rd(rd_a), .rom_addr(radr_a),
        .rom_data(romd_a),
        .owner(own_a)
`ifdef GLYPH_ARB_STATS_EN
        , .conflicts(conf_a)
`endif
    );

    glyph_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(8)) dut_b (
        .clk_in(clk_in), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0_b), .gnt1(gnt1_b),
        .rvalid0(rv0_b), .rvalid1(rv1_b),
        .rdata(rdata_b),
        .rom_rd(rd_b), .rom_addr(radr_b),
        .rom_data(romd_b),
        .owner(own_b)
`ifdef GLYPH_ARB_STATS_EN
        , .conflicts(conf_b)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        int v;
        v = int'(a);
        return DW'(((v * 3) + 7) ^ 42);
    endfunction

    always @(posedge clk_in) begin
        romd_a <= rom_f(radr_a);
        romd_b <= rom_f(radr_b);
    end

    always_comb begin
        gnt0     = sel ? gnt0_b : gnt0_a;
        gnt1     = sel ? gnt1_b : gnt1_a;
        rvalid0  = sel ? rv0_b : rv0_a;
        rvalid1  = sel ? rv1_b : rv1_a;
        rdata    = sel ? rdata_b : rdata_a;
        rom_rd   = sel ? rd_b : rd_a;
        rom_addr = sel ? radr_b : radr_a;
        owner    = sel ? own_b : own_a;
    end

    function automatic vec_t mk(
        input logic r0, input logic r1,
        input logic l0, input logic l1,
        input int a0, input int a1,
        input logic e0, input logic e1,
        input int own);
        vec_t v;
        v.r0 = r0; v.r1 = r1;
        v.l0 = l0; v.l1 = l1;
        v.a0 = AW'(a0); v.a1 = AW'(a1);
        v.e0 = e0; v.e1 = e1;
        v.own = 2'(own);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h",
                     nm, stepno, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        exp_t p;
        logic [AW-1:0] xa;
        req0 = v.r0; req1 = v.r1;
        lock0 = v.l0; lock1 = v.l1;
        addr0 = v.a0; addr1 = v.a1;
        @(negedge clk_in);
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            p = '{1'b0, 1'b0, '0};
        end else begin
            p = sbq.pop_front();
        end
        chk("rvalid0", 32'(rvalid0), 32'(p.v0));
        chk("rvalid1", 32'(rvalid1), 32'(p.v1));
        if (p.v0 || p.v1) chk("rdata", 32'(rdata), 32'(p.d));
        xa = v.e0 ? v.a0 : (v.e1 ? v.a1 : '0);
        chk("gnt0", 32'(gnt0), 32'(v.e0));
        chk("gnt1", 32'(gnt1), 32'(v.e1));
        chk("rom_rd", 32'(rom_rd), 32'(v.e0 | v.e1));
        chk("rom_addr", 32'(rom_addr), 32'(xa));
        chk("owner", 32'(owner), 32'(v.own));
        e.v0 = v.e0;
        e.v1 = v.e1;
        e.d  = rom_f(xa);
        sbq.push_back(e);
        stepno++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0;
        rst = 1'b1;
        #1;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        sbq.delete();
        sbq.push_back('{1'b0, 1'b0, '0});
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 10, 20, 1, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 11, 21, 0, 1, 0);
        tbl[2]  = mk(1, 1, 0, 0, 12, 22, 1, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 13, 23, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 23, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 5, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 6, 0, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 1, 0, 9, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 1, 44, 45, 0, 1, 2);
        tbl[11] = mk(1, 0, 0, 0, 46, 0, 0, 0, 2);
        tbl[12] = mk(1, 0, 0, 0, 47, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #2;
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) step(tbl[i]);

        // lock burst: ten reads by 0, requester 1 starved until release
        do_reset();
        for (int i = 0; i < 10; i++)
            step(mk(1, 1, 1, 0, 30 + i, 50, 1, 0, (i == 0) ? 0 : 1));
        step(mk(1, 1, 0, 0, 40, 50, 1, 0, 1));
        step(mk(1, 1, 0, 0, 41, 51, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // lock timeout on the LOCK_MAX=8 instance
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++)
            step(mk(1, 1, 1, 0, i, 60, 1, 0, (i == 0) ? 0 : 1));
        step(mk(1, 1, 1, 0, 9, 61, 0, 1, 0));
        step(mk(1, 1, 1, 0, 10, 62, 1, 0, 0));
        step(mk(1, 1, 1, 0, 11, 63, 1, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset while a grant to 1 is in flight and OWN1 was just entered
        sel = 1'b0;
        do_reset();
        step(mk(0, 1, 0, 1, 0, 77, 0, 1, 0));
        chk("pre_rst_rvalid1", 32'(rvalid1), 32'd1);
        chk("pre_rst_owner", 32'(owner), 32'd2);
        do_reset();
        step(mk(1, 1, 0, 0, 3, 4, 1, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef GLYPH_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 6; i++)
            step(mk(1, 1, 0, 0, 8, 9, (i % 2) == 0, (i % 2) == 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("conflicts", 32'(sel ? conf_b : conf_a), 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
